// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter.
// Holds the FSM state encoding, the stall vector bit indices and the
// common Enable/Disable/ZeroWord constants used across the arbiter files.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIfBusy  = 2'd1,
    StMemBusy = 2'd2
  } arb_state_e;

  // Pipeline register each stall bit freezes
  localparam int unsigned STALL_PC    = 0;
  localparam int unsigned STALL_IFID  = 1;
  localparam int unsigned STALL_IDEX  = 2;
  localparam int unsigned STALL_EXMEM = 3;
  localparam int unsigned STALL_MEMWB = 4;

  localparam logic        Enable   = 1'b1;
  localparam logic        Disable  = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-port memory bus between the arbiter (master) and the memory (slave).
//   bus_req   master->slave  transaction active
//   bus_we    master->slave  write enable
//   bus_addr  master->slave  address
//   bus_wdata master->slave  write data
//   bus_ack   slave->master  one-cycle completion
//   bus_rdata slave->master  read data, valid with bus_ack
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/mem_arb_wdt.sv
// Busy-state watchdog for the memory port arbiter (used only when
// MEM_ARB_TIMEOUT_EN is defined).
//   dclk, rst  clock and asynchronous active-high reset
//   start      arbiter enters a busy state at the next edge; clears the count
//   busy       arbiter is currently in a busy state
//   expire     this is the TIMEOUT_CYCLES-th busy cycle
module mem_arb_wdt #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic dclk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  output logic expire
);

  // Count starts at 0 in the first busy cycle, so cycle N holds N-1
  localparam logic [9:0] Limit = 10'(TIMEOUT_CYCLES - 1);

  logic [9:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + 10'd1;
    end
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = busy && (cnt_q == Limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch (IF) and
// load/store (MEM), MEM having fixed priority. Transactions are
// non-preemptive; each completes with a one-cycle done pulse and, for reads,
// registered read data. Drives the pipeline stall vector.
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a busy-state watchdog
// that aborts a transaction after TIMEOUT_CYCLES cycles and pulses err.
//   dclk, rst                         clock, asynchronous active-high reset
//   if_req/if_addr                    IF fetch request (held until if_done)
//   if_rdata/if_done                  IF read data and completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata MEM request (held until mem_done)
//   mem_rdata/mem_done                MEM load data and completion pulse
//   bus                               memory bus (master modport)
//   stall                             {MEM/WB, EX/MEM, ID/EX, IF/ID, PC}
//   err                               one-cycle timeout pulse
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 dclk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [ADDR_W-1:0]    if_addr,
  output logic [DATA_W-1:0]    if_rdata,
  output logic                 if_done,
  input  logic                 mem_req,
  input  logic                 mem_we,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_wdata,
  output logic [DATA_W-1:0]    mem_rdata,
  output logic                 mem_done,
  mem_port_arbiter_if.master   bus,
  output logic [4:0]           stall,
  output logic                 err
);

  arb_state_e        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic              busy;
  logic              timeout;

  assign busy = (state_q != StIdle);

`ifdef MEM_ARB_TIMEOUT_EN
  logic wdt_start;
  logic err_q;

  assign wdt_start = (state_q == StIdle) && (state_d != StIdle);

  mem_arb_wdt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdt (
    .dclk  (dclk),
    .rst   (rst),
    .start (wdt_start),
    .busy  (busy),
    .expire(timeout)
  );

  // A coincident bus_ack completes the transaction normally
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      err_q <= Disable;
    end else begin
      err_q <= timeout && !bus.bus_ack;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = Disable;
  assign err     = Disable;
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = Disable;
    mem_done_d  = Disable;
    case (state_q)
      StIdle: begin
        // A requester is not re-accepted while its own done pulse is high
        if (mem_req && !mem_done_q) begin
          state_d     = StMemBusy;
          bus_req_d   = Enable;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
        end else if (if_req && !if_done_q) begin
          state_d    = StIfBusy;
          bus_req_d  = Enable;
          bus_we_d   = Disable;
          bus_addr_d = if_addr;
        end
      end
      StIfBusy, StMemBusy: begin
        if (bus.bus_ack || timeout) begin
          state_d   = StIdle;
          bus_req_d = Disable;
          bus_we_d  = Disable;
          if (state_q == StIfBusy) begin
            if_done_d  = Enable;
            if_rdata_d = bus.bus_ack ? bus.bus_rdata : '0;
          end else begin
            mem_done_d = Enable;
            if (!bus_we_q) begin
              mem_rdata_d = bus.bus_ack ? bus.bus_rdata : '0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      bus_req_q   <= Disable;
      bus_we_q    <= Disable;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= Disable;
      mem_done_q  <= Disable;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  // MEM/WB is never stalled; it takes a bubble instead
  always_comb begin
    stall = '0;
    if (!rst) begin
      if (mem_req && !mem_done_q) begin
        stall[STALL_EXMEM:STALL_PC] = 4'b1111;
      end else if (if_req && !if_done_q) begin
        stall[STALL_PC] = Enable;
      end
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign if_rdata      = if_rdata_q;
  assign mem_rdata     = mem_rdata_q;
  assign if_done       = if_done_q;
  assign mem_done      = mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned Tmo = 4;
`else
  localparam int unsigned Tmo = 255;
`endif

  logic        dclk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata;
  logic        if_done, mem_done, err;
  logic [4:0]  stall;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .dclk(dclk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .bus(bus_if), .stall(stall), .err(err)
  );

  always #5 dclk = ~dclk;

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 0; mem_req = 0; mem_we = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    bus_if.bus_ack = 0; bus_if.bus_rdata = '0;
    #22;
    n_vec++; if ({bus_if.bus_req, bus_if.bus_we, if_done, mem_done, err} !== 5'b0) begin
      n_err++; $display("FAIL reset.ctrl got %b want 00000",
                        {bus_if.bus_req, bus_if.bus_we, if_done, mem_done, err}); end
    n_vec++; if ({bus_if.bus_addr, bus_if.bus_wdata, if_rdata, mem_rdata} !== 128'h0) begin
      n_err++; $display("FAIL reset.data got %h want 0",
                        {bus_if.bus_addr, bus_if.bus_wdata, if_rdata, mem_rdata}); end
    if_req = 1; mem_req = 1;
    #1;
    n_vec++; if (stall !== 5'b0) begin
      n_err++; $display("FAIL reset.stall got %b want 00000", stall); end
    if_req = 0; mem_req = 0;
    @(negedge dclk) rst = 1'b0;
    tick();
    n_vec++; if (bus_if.bus_req !== 1'b0) begin
      n_err++; $display("FAIL reset.idle got %b want 0", bus_if.bus_req); end
  endtask

  task automatic test_if_read();
    if_req = 1; if_addr = 32'h100;
    #1;
    n_vec++; if (stall !== 5'b00001) begin
      n_err++; $display("FAIL if_read.stall0 got %b want 00001", stall); end
    tick();
    n_vec++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr} !== {2'b10, 32'h100}) begin
      n_err++; $display("FAIL if_read.bus got %b %b %h want 1 0 100",
                        bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr); end
    n_vec++; if ({if_done, stall} !== 6'b0_00001) begin
      n_err++; $display("FAIL if_read.busy got done %b stall %b want 0 00001", if_done, stall); end
    bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h00A00093;
    tick();
    bus_if.bus_ack = 0; bus_if.bus_rdata = '0;
    n_vec++; if ({if_done, bus_if.bus_req, stall} !== 7'b10_00000) begin
      n_err++; $display("FAIL if_read.done got done %b req %b stall %b want 1 0 00000",
                        if_done, bus_if.bus_req, stall); end
    n_vec++; if (if_rdata !== 32'h00A00093) begin
      n_err++; $display("FAIL if_read.rdata got %h want 00a00093", if_rdata); end
    if_req = 0;
    tick();
    n_vec++; if ({if_done, bus_if.bus_req} !== 2'b00) begin
      n_err++; $display("FAIL if_read.after got %b want 00", {if_done, bus_if.bus_req}); end
  endtask

  task automatic test_store();
    mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF;
    tick();
    for (int i = 1; i <= 3; i++) begin
      n_vec++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata}
                   !== {2'b11, 32'h200, 32'hDEADBEEF}) begin
        n_err++; $display("FAIL store.bus%0d got %b %b %h %h want 1 1 200 deadbeef", i,
                          bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata); end
      n_vec++; if ({mem_done, stall} !== 6'b0_01111) begin
        n_err++; $display("FAIL store.stall%0d got done %b stall %b want 0 01111",
                          i, mem_done, stall); end
      if (i == 3) bus_if.bus_ack = 1;
      if (i < 3) tick();
    end
    tick();
    bus_if.bus_ack = 0;
    n_vec++; if ({mem_done, bus_if.bus_req, bus_if.bus_we} !== 3'b100) begin
      n_err++; $display("FAIL store.done got %b want 100",
                        {mem_done, bus_if.bus_req, bus_if.bus_we}); end
    n_vec++; if (mem_rdata !== 32'h0) begin
      n_err++; $display("FAIL store.rdata got %h want 00000000", mem_rdata); end
    mem_req = 0; mem_we = 0;
    tick();
    n_vec++; if (mem_done !== 1'b0) begin
      n_err++; $display("FAIL store.pulse got %b want 0", mem_done); end
  endtask

  task automatic test_contention();
    if_req = 1; if_addr = 32'h300;
    mem_req = 1; mem_we = 0; mem_addr = 32'h400;
    tick();
    n_vec++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr} !== {2'b10, 32'h400}) begin
      n_err++; $display("FAIL contention.mem_first got %b %b %h want 1 0 400",
                        bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr); end
    n_vec++; if (stall !== 5'b01111) begin
      n_err++; $display("FAIL contention.stall_mem got %b want 01111", stall); end
    bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h11112222;
    tick();
    bus_if.bus_ack = 0;
    n_vec++; if ({mem_done, if_done, mem_rdata} !== {2'b10, 32'h11112222}) begin
      n_err++; $display("FAIL contention.mem_done got %b %b %h want 1 0 11112222",
                        mem_done, if_done, mem_rdata); end
    n_vec++; if (stall !== 5'b00001) begin
      n_err++; $display("FAIL contention.stall_rel got %b want 00001", stall); end
    mem_req = 0;
    tick();
    n_vec++; if ({bus_if.bus_req, bus_if.bus_addr} !== {1'b1, 32'h300}) begin
      n_err++; $display("FAIL contention.if_grant got %b %h want 1 300",
                        bus_if.bus_req, bus_if.bus_addr); end
    bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h33334444;
    tick();
    bus_if.bus_ack = 0;
    n_vec++; if ({if_done, if_rdata} !== {1'b1, 32'h33334444}) begin
      n_err++; $display("FAIL contention.if_done got %b %h want 1 33334444", if_done, if_rdata);
    end
    if_req = 0;
    tick();
  endtask

  task automatic test_mem_during_if();
    if_req = 1; if_addr = 32'h500;
    tick();
    mem_req = 1; mem_we = 1; mem_addr = 32'h600; mem_wdata = 32'hCAFEF00D;
    tick();
    n_vec++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr} !== {2'b10, 32'h500}) begin
      n_err++; $display("FAIL mem_during_if.hold got %b %b %h want 1 0 500",
                        bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr); end
    n_vec++; if (stall !== 5'b01111) begin
      n_err++; $display("FAIL mem_during_if.stall got %b want 01111", stall); end
    bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h55556666;
    tick();
    bus_if.bus_ack = 0;
    n_vec++; if ({if_done, mem_done, bus_if.bus_req, if_rdata} !== {3'b100, 32'h55556666}) begin
      n_err++; $display("FAIL mem_during_if.if_done got %b%b%b %h want 100 55556666",
                        if_done, mem_done, bus_if.bus_req, if_rdata); end
    if_req = 0;
    tick();
    n_vec++; if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata}
                 !== {2'b11, 32'h600, 32'hCAFEF00D}) begin
      n_err++; $display("FAIL mem_during_if.mem_grant got %b %b %h %h want 1 1 600 cafef00d",
                        bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata); end
    bus_if.bus_ack = 1;
    tick();
    bus_if.bus_ack = 0;
    n_vec++; if ({mem_done, mem_rdata} !== {1'b1, 32'h11112222}) begin
      n_err++; $display("FAIL mem_during_if.mem_done got %b %h want 1 11112222",
                        mem_done, mem_rdata); end
    mem_req = 0; mem_we = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    mem_req = 1; mem_we = 0; mem_addr = 32'h700;
    tick();
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({bus_if.bus_req, mem_done, stall} !== 7'b0) begin
      n_err++; $display("FAIL reset_mid.drop got req %b done %b stall %b want 0 0 00000",
                        bus_if.bus_req, mem_done, stall); end
    @(posedge dclk);
    @(negedge dclk) rst = 1'b0;
    #1;
    n_vec++; if ({bus_if.bus_req, mem_done} !== 2'b00) begin
      n_err++; $display("FAIL reset_mid.idle got %b want 00", {bus_if.bus_req, mem_done}); end
    tick();
    n_vec++; if ({bus_if.bus_req, bus_if.bus_addr} !== {1'b1, 32'h700}) begin
      n_err++; $display("FAIL reset_mid.restart got %b %h want 1 700",
                        bus_if.bus_req, bus_if.bus_addr); end
    bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h77778888;
    tick();
    bus_if.bus_ack = 0;
    n_vec++; if ({mem_done, mem_rdata} !== {1'b1, 32'h77778888}) begin
      n_err++; $display("FAIL reset_mid.done got %b %h want 1 77778888", mem_done, mem_rdata);
    end
    mem_req = 0;
    tick();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    mem_req = 1; mem_we = 0; mem_addr = 32'h900;
    tick();
    for (int i = 2; i <= 4; i++) begin
      tick();
      n_vec++; if ({mem_done, err, bus_if.bus_req} !== 3'b001) begin
        n_err++; $display("FAIL timeout.wait%0d got %b want 001",
                          i, {mem_done, err, bus_if.bus_req}); end
    end
    tick();
    n_vec++; if ({mem_done, err, bus_if.bus_req, mem_rdata} !== {3'b110, 32'h0}) begin
      n_err++; $display("FAIL timeout.fire got %b %b %b %h want 1 1 0 00000000",
                        mem_done, err, bus_if.bus_req, mem_rdata); end
    mem_req = 0;
    tick();
    n_vec++; if ({mem_done, err} !== 2'b00) begin
      n_err++; $display("FAIL timeout.pulse got %b want 00", {mem_done, err}); end
    mem_req = 1;
    tick();
    tick();
    tick();
    tick();
    bus_if.bus_ack = 1; bus_if.bus_rdata = 32'hABCD0123;
    tick();
    bus_if.bus_ack = 0;
    n_vec++; if ({mem_done, err, mem_rdata} !== {2'b10, 32'hABCD0123}) begin
      n_err++; $display("FAIL timeout.ack_wins got %b %b %h want 1 0 abcd0123",
                        mem_done, err, mem_rdata); end
    mem_req = 0;
    tick();
  endtask
`endif

  // Transaction-level reference: who owns the bus, what it asked for, and
  // which done pulse the bench's own ack must produce.
  task automatic test_random(input int n_cycles);
    int          own;
    int          wait_cnt;
    logic        x_if_done, x_mem_done, p_if_done, p_mem_done;
    logic        have_fetch, have_load, ack_v, cur_we;
    logic [31:0] x_if_rdata, x_mem_rdata, cur_addr, cur_wdata, ack_data;
    logic [4:0]  x_stall;
    logic [31:0] model_mem [logic [31:0]];
    own = 0; wait_cnt = 0; cur_we = 0; cur_addr = '0; cur_wdata = '0;
    x_if_done = 0; x_mem_done = 0; have_fetch = 0; have_load = 0;
    x_if_rdata = '0; x_mem_rdata = '0;
    for (int c = 0; c < n_cycles; c++) begin
      ack_v = bus_if.bus_ack; ack_data = bus_if.bus_rdata;
      @(posedge dclk);
      p_if_done = x_if_done; p_mem_done = x_mem_done;
      x_if_done = 0; x_mem_done = 0;
      if (own != 0) begin
        if (ack_v) begin
          if (own == 1) begin
            x_if_done = 1; x_if_rdata = ack_data; have_fetch = 1;
          end else begin
            x_mem_done = 1;
            if (cur_we) model_mem[cur_addr] = cur_wdata;
            else begin x_mem_rdata = ack_data; have_load = 1; end
          end
          own = 0;
        end
      end else if (mem_req && !p_mem_done) begin
        own = 2; cur_addr = mem_addr; cur_we = mem_we; cur_wdata = mem_wdata;
        wait_cnt = $urandom_range(0, 3);
      end else if (if_req && !p_if_done) begin
        own = 1; cur_addr = if_addr; cur_we = 0;
        wait_cnt = $urandom_range(0, 3);
      end
      #1;
      n_vec++; if (bus_if.bus_req !== (own != 0)) begin
        n_err++; $display("FAIL random.bus_req c%0d got %b want %b", c, bus_if.bus_req, own != 0);
      end
      if (own != 0) begin
        n_vec++; if ({bus_if.bus_we, bus_if.bus_addr} !== {cur_we, cur_addr}) begin
          n_err++; $display("FAIL random.bus c%0d got %b %h want %b %h", c,
                            bus_if.bus_we, bus_if.bus_addr, cur_we, cur_addr); end
        if (cur_we) begin
          n_vec++; if (bus_if.bus_wdata !== cur_wdata) begin
            n_err++; $display("FAIL random.wdata c%0d got %h want %h", c,
                              bus_if.bus_wdata, cur_wdata); end
        end
      end
      n_vec++; if ({if_done, mem_done, err} !== {x_if_done, x_mem_done, 1'b0}) begin
        n_err++; $display("FAIL random.done c%0d got %b want %b", c,
                          {if_done, mem_done, err}, {x_if_done, x_mem_done, 1'b0}); end
      if (have_fetch) begin
        n_vec++; if (if_rdata !== x_if_rdata) begin
          n_err++; $display("FAIL random.if_rdata c%0d got %h want %h", c, if_rdata, x_if_rdata);
        end
      end
      if (have_load) begin
        n_vec++; if (mem_rdata !== x_mem_rdata) begin
          n_err++; $display("FAIL random.mem_rdata c%0d got %h want %h", c,
                            mem_rdata, x_mem_rdata); end
      end
      // Requesters: hold until done, then usually drop
      if (x_if_done) begin
        if ($urandom_range(0, 3) != 0) if_req = 0;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = {16'h0000, 16'($urandom)} & 32'hFFFF_FFFC;
      end
      if (x_mem_done) begin
        if ($urandom_range(0, 3) != 0) mem_req = 0;
      end else if (!mem_req && $urandom_range(0, 2) == 0) begin
        mem_req = 1; mem_we = 1'($urandom);
        mem_addr = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2);
        mem_wdata = $urandom;
      end
      // Memory: ack after the chosen latency; stray acks while idle are noise
      if (own != 0) begin
        if (wait_cnt == 0) begin
          bus_if.bus_ack = 1;
          if (cur_we) bus_if.bus_rdata = $urandom;
          else if (model_mem.exists(cur_addr)) bus_if.bus_rdata = model_mem[cur_addr];
          else bus_if.bus_rdata = ~cur_addr;
        end else begin
          wait_cnt--; bus_if.bus_ack = 0; bus_if.bus_rdata = $urandom;
        end
      end else begin
        bus_if.bus_ack = ($urandom_range(0, 7) == 0); bus_if.bus_rdata = $urandom;
      end
      #1;
      if (mem_req && !x_mem_done) x_stall = 5'b01111;
      else if (if_req && !x_if_done) x_stall = 5'b00001;
      else x_stall = 5'b00000;
      n_vec++; if (stall !== x_stall) begin
        n_err++; $display("FAIL random.stall c%0d got %b want %b", c, stall, x_stall); end
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_store();
    test_contention();
    test_mem_during_if();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
